// File: rtl/aes_subbytes_serial.sv
// Serial AES SubBytes engine: one byte per cycle through a single S-box,
// with optional ShiftRows applied combinationally on the output.

module des_sbox (
   input  logic [7:0] in,
   output logic [7:0] out
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Inverse as x^254 (square-and-multiply); maps 0 to 0 as AES requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] t;
      logic [7:0] r;
      t = gf_mul(x, x);
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         r = gf_mul(r, t);
         t = gf_mul(t, t);
      end
      return r;
   endfunction

   logic [7:0] w_inv;

   always_comb begin
      w_inv = gf_inv(in);
      out   = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
            ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
   end

endmodule

// state | meaning
// IDLE  | waiting for in_valid; in_ready high when not in reset
// SUB   | substituting byte cnt of wr each cycle
// HOLD  | result presented on out_state until out_ready
module aes_subbytes_serial #(
   parameter int SHIFT_ROWS = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, SUB, HOLD} state_t;

   state_t       r_state;
   logic [3:0]   r_cnt;
   logic [127:0] r_wr;
   logic         r_out_valid;
   logic         r_busy;

   logic [7:0]   w_bytes [16];
   logic [7:0]   w_sb_in;
   logic [7:0]   w_sb_out;
   logic [127:0] w_wr_sub;

   genvar k;
   generate
      for (k = 0; k < 16; k++) begin : g_byte
         assign w_bytes[k] = r_wr[127-8*k -: 8];
         assign w_wr_sub[127-8*k -: 8] = (r_cnt == 4'(k)) ? w_sb_out : r_wr[127-8*k -: 8];
      end
   endgenerate

   assign w_sb_in = w_bytes[r_cnt];

   des_sbox u_sbox (
      .in  (w_sb_in),
      .out (w_sb_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= 4'd0;
         r_wr        <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_wr    <= in_state;
                  r_cnt   <= 4'd0;
                  r_state <= SUB;
                  r_busy  <= 1'b1;
               end
            end
            SUB: begin
               r_wr  <= w_wr_sub;
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt == 4'd15) begin
                  r_state     <= HOLD;
                  r_out_valid <= 1'b1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE) && !rst;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;

   // Output byte (row r, col c) takes wr byte (r, (c+r) mod 4).
   generate
      if (SHIFT_ROWS != 0) begin : g_shift
         genvar c, r;
         for (c = 0; c < 4; c++) begin : g_col
            for (r = 0; r < 4; r++) begin : g_row
               assign out_state[127-8*(4*c+r) -: 8] = r_wr[127-8*(4*((c+r)%4)+r) -: 8];
            end
         end
      end else begin : g_plain
         assign out_state = r_wr;
      end
   endgenerate

endmodule

// File: tb/tb_aes_subbytes_serial.sv
// Bench for aes_subbytes_serial: both SHIFT_ROWS variants side by side,
// checked against an arithmetic AES S-box / ShiftRows model.

module tb_aes_subbytes_serial;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic [127:0] in_state;
   logic         out_ready;
   logic         in_ready0, in_ready1;
   logic         out_valid0, out_valid1;
   logic [127:0] out_state0, out_state1;
   logic         busy0, busy1;

   int total;
   int bad;
   int sb [256];

   aes_subbytes_serial #(.SHIFT_ROWS(0)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
      .in_state(in_state), .out_valid(out_valid0), .out_ready(out_ready),
      .out_state(out_state0), .busy(busy0)
   );

   aes_subbytes_serial #(.SHIFT_ROWS(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
      .in_state(in_state), .out_valid(out_valid1), .out_ready(out_ready),
      .out_state(out_state1), .busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int gmul(input int a, input int b);
      int p;
      p = 0;
      for (int i = 0; i < 8; i++)
         if (((b >> i) & 1) != 0) p = p ^ (a << i);
      for (int bit_i = 14; bit_i >= 8; bit_i--)
         if (((p >> bit_i) & 1) != 0) p = p ^ (32'h11b << (bit_i - 8));
      return p;
   endfunction

   function automatic int rotl8(input int x, input int n);
      return ((x << n) | (x >> (8 - n))) & 255;
   endfunction

   task automatic build_sbox();
      int inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 0;
         for (int y = 1; y < 256; y++)
            if (gmul(x, y) == 1) inv = y;
         s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 32'h63;
         sb[x] = s;
      end
   endtask

   function automatic logic [127:0] ref_sub(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0] b;
      o = '0;
      for (int i = 0; i < 16; i++) begin
         b = s[127-8*i -: 8];
         o[127-8*i -: 8] = 8'(sb[b]);
      end
      return o;
   endfunction

   function automatic logic [127:0] ref_shift(input logic [127:0] s);
      logic [7:0] m [4][4];
      logic [7:0] n [4][4];
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            m[r][c] = s[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            n[r][c] = m[r][(c + r) % 4];
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = n[r][c];
      return o;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [127:0] s);
      in_valid = 1'b1;
      in_state = s;
      step();
      in_valid = 1'b0;
   endtask

   // Walks edges T+1..T+16 after acceptance; reports whether out_valid rose early.
   task automatic run_to_hold(input bit rand_ready, output bit early);
      early = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
         step();
         if (out_valid0 || out_valid1) early = 1'b1;
      end
      out_ready = 1'b0;
      step();
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_state = '0; out_ready = 1'b0;
      #2;
      total++;
      if ({in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1} !== 6'b0) begin
         bad++;
         $display("FAIL reset_ctrl got=%b exp=000000",
                  {in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1});
      end
      total++;
      if (out_state0 !== '0 || out_state1 !== '0) begin
         bad++;
         $display("FAIL reset_state got=%h/%h exp=0", out_state0, out_state1);
      end
      step(); step();
      rst = 1'b0;
      step();
      total++;
      if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
         bad++;
         $display("FAIL reset_release_ready got=%b%b exp=11", in_ready0, in_ready1);
      end
   endtask

   task automatic test_known(input logic [127:0] s, input logic [127:0] e0, input logic [127:0] e1);
      bit early;
      accept(s);
      total++;
      if (busy0 !== 1'b1 || in_ready0 !== 1'b0) begin
         bad++;
         $display("FAIL known_busy got=%b%b exp=10", busy0, in_ready0);
      end
      run_to_hold(1'b0, early);
      total++;
      if (early || out_valid0 !== 1'b1 || out_valid1 !== 1'b1) begin
         bad++;
         $display("FAIL known_latency early=%0d got=%b%b exp=11", early, out_valid0, out_valid1);
      end
      total++;
      if (out_state0 !== e0) begin
         bad++;
         $display("FAIL known_sub got=%h exp=%h", out_state0, e0);
      end
      total++;
      if (out_state1 !== e1) begin
         bad++;
         $display("FAIL known_shift got=%h exp=%h", out_state1, e1);
      end
      release_out();
      total++;
      if (in_ready0 !== 1'b1 || busy0 !== 1'b0 || out_valid0 !== 1'b0) begin
         bad++;
         $display("FAIL known_return got=%b%b%b exp=100", in_ready0, busy0, out_valid0);
      end
   endtask

   task automatic test_random();
      logic [127:0] s;
      bit early;
      for (int it = 0; it < 12; it++) begin
         s = {$urandom, $urandom, $urandom, $urandom};
         accept(s);
         run_to_hold(1'b1, early);
         total++;
         if (early || out_valid0 !== 1'b1) begin
            bad++;
            $display("FAIL rand_valid it=%0d early=%0d got=%b exp=1", it, early, out_valid0);
         end
         total++;
         if (out_state0 !== ref_sub(s) || out_state1 !== ref_shift(ref_sub(s))) begin
            bad++;
            $display("FAIL rand_data it=%0d got=%h/%h exp=%h/%h", it, out_state0, out_state1,
                     ref_sub(s), ref_shift(ref_sub(s)));
         end
         repeat ($urandom_range(0, 3)) step();
         release_out();
         total++;
         if (busy1 !== 1'b0 || in_ready1 !== 1'b1) begin
            bad++;
            $display("FAIL rand_return it=%0d got=%b%b exp=01", it, busy1, in_ready1);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] s;
      bit early;
      bit unstable;
      s = {$urandom, $urandom, $urandom, $urandom};
      accept(s);
      run_to_hold(1'b0, early);
      unstable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (out_valid0 !== 1'b1 || out_valid1 !== 1'b1 || in_ready0 !== 1'b0 ||
             out_state0 !== ref_sub(s) || out_state1 !== ref_shift(ref_sub(s)))
            unstable = 1'b1;
      end
      total++;
      if (unstable) begin
         bad++;
         $display("FAIL bp_hold got=%h exp=%h stable=0", out_state0, ref_sub(s));
      end
      release_out();
      total++;
      if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
         bad++;
         $display("FAIL bp_release got=%b%b exp=10", in_ready0, out_valid0);
      end
   endtask

   task automatic test_ignore();
      logic [127:0] a, b;
      bit early;
      a = {$urandom, $urandom, $urandom, $urandom};
      b = ~a;
      accept(a);
      in_valid = 1'b1;
      in_state = b;
      run_to_hold(1'b0, early);
      step(); step();
      total++;
      if (out_state0 !== ref_sub(a) || out_valid0 !== 1'b1) begin
         bad++;
         $display("FAIL ignore_first got=%h exp=%h", out_state0, ref_sub(a));
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total++;
      if (busy0 !== 1'b0) begin
         bad++;
         $display("FAIL ignore_no_same_edge got=%b exp=0", busy0);
      end
      step();
      in_valid = 1'b0;
      run_to_hold(1'b0, early);
      total++;
      if (early || out_valid1 !== 1'b1 || out_state1 !== ref_shift(ref_sub(b))) begin
         bad++;
         $display("FAIL ignore_second got=%h exp=%h", out_state1, ref_shift(ref_sub(b)));
      end
      release_out();
   endtask

   task automatic test_reset_mid();
      logic [127:0] s;
      bit early;
      s = {$urandom, $urandom, $urandom, $urandom};
      accept(s);
      repeat (7) step();
      rst = 1'b1;
      #1;
      total++;
      if ({in_ready0, out_valid0, busy0, busy1} !== 4'b0 || out_state0 !== '0 || out_state1 !== '0) begin
         bad++;
         $display("FAIL midrst_outputs got=%b %h %h exp=0000 0 0",
                  {in_ready0, out_valid0, busy0, busy1}, out_state0, out_state1);
      end
      step();
      rst = 1'b0;
      step();
      total++;
      if (in_ready0 !== 1'b1) begin
         bad++;
         $display("FAIL midrst_ready got=%b exp=1", in_ready0);
      end
      accept('0);
      run_to_hold(1'b0, early);
      total++;
      if (early || out_valid0 !== 1'b1 || out_state0 !== {16{8'h63}} || out_state1 !== {16{8'h63}}) begin
         bad++;
         $display("FAIL midrst_fresh early=%0d got=%h exp=%h", early, out_state0, {16{8'h63}});
      end
      release_out();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      build_sbox();
      test_reset();
      test_known('0, {16{8'h63}}, {16{8'h63}});
      test_known(128'h00112233445566778899aabbccddeeff,
                 128'h638293c31bfc33f5c4eeacea4bc12816,
                 128'h63fcac161bee28c3c4c193f54b8233ea);
      test_random();
      test_backpressure();
      test_ignore();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/aes_subbytes_serial.md
AES_SUBBYTES_SERIAL -- requirements
Module: aes_subbytes_serial

Interface
REQ-001 Parameter: SHIFT_ROWS, default 0. 0 = SubBytes only; 1 = SubBytes followed by ShiftRows on the output.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  in_state is presented for acceptance.
REQ-005 in_ready  output  1  block can accept a new state.
REQ-006 in_state  input  128  AES state. Byte k occupies bits [127-8k -: 8]; k = 4*col + row.
REQ-007 out_valid  output  1  out_state holds a completed result.
REQ-008 out_ready  input  1  consumer accepts out_state.
REQ-009 out_state  output  128  substituted (and optionally shifted) state, same byte order as in_state.
REQ-010 busy  output  1  block is not in IDLE.

Function
REQ-011 The block SHALL be one clock domain with one asynchronous active-high reset, as stated in REQ-002/REQ-003.
REQ-012 The block SHALL instantiate exactly one des_sbox (in[7:0] -> out[7:0], combinational) and process one byte per cycle through it.
REQ-013 The FSM SHALL have exactly three states: IDLE, SUB and HOLD. It SHALL also keep a 4-bit byte counter cnt and a 128-bit working register wr.
REQ-014 in_ready SHALL be 1 only in IDLE and only when rst is 0.
REQ-015 In IDLE, when in_valid=1 at a clock edge, the block SHALL set wr <= in_state and cnt <= 0, and move to SUB.
REQ-016 In SUB, each edge SHALL replace byte cnt of wr with des_sbox(byte cnt of wr) and set cnt <= cnt+1.
REQ-017 When cnt=15 in SUB, the edge SHALL write byte 15, set cnt to 0, and move to HOLD.
REQ-018 Latency: if a state is accepted at edge T, out_valid SHALL first be 1 after edge T+16.
REQ-019 In HOLD, out_valid SHALL be 1 and out_state SHALL be held stable until the edge where out_ready=1.
REQ-020 On the out_ready edge in HOLD, the block SHALL return to IDLE. The next input cannot be accepted on that same edge, so the minimum input-to-input spacing is 18 cycles.
REQ-021 out_valid SHALL be 0 in IDLE and SUB. If out_ready arrives outside HOLD, it SHALL be ignored.
REQ-022 in_valid and in_state SHALL be ignored in SUB and HOLD; a new state is never captured while busy.
REQ-023 With SHIFT_ROWS=0, out_state SHALL equal wr.
REQ-024 With SHIFT_ROWS=1, out_state SHALL be ShiftRows(wr), computed combinationally: output byte (row r, col c) = wr byte (r, (c+r) mod 4).
REQ-025 busy SHALL be 1 in SUB and HOLD and 0 in IDLE.
REQ-026 out_state SHALL carry no timing or functional meaning while out_valid=0, but SHALL be deterministic (driven from wr).

Reset
REQ-027 While rst=1, the block SHALL hold: state=IDLE, cnt=0, wr=0, out_valid=0, busy=0, in_ready=0, out_state = all-zero (SHIFT_ROWS=1 also gives 0).
REQ-028 If rst asserts mid-SUB or in HOLD, the block SHALL abort immediately with no output produced; the partial result SHALL be discarded.
REQ-029 On the first edge after rst deasserts, in_ready SHALL be 1.

Verification
REQ-030 SHIFT_ROWS=0: in_state=0 accepted at edge T -> out_valid=1 after T+16, out_state=63636363636363636363636363636363.
REQ-031 SHIFT_ROWS=0: in_state=00112233445566778899aabbccddeeff -> out_state=638293c31bfc33f5c4eeacea4bc12816.
REQ-032 SHIFT_ROWS=1, same input as REQ-031 -> out_state=63fcac161bee28c3c4c193f54b8233ea.
REQ-033 Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid and out_state stable throughout, in_ready=0 throughout. Then out_ready=1 for one cycle -> IDLE, in_ready=1 on the next cycle.
REQ-034 in_valid=1 with a different in_state during SUB and HOLD -> not captured; result still matches the first input, and the second state is taken only once back in IDLE.
REQ-035 rst pulse at cnt=7 -> all outputs at reset values immediately. A fresh all-zero input after reset -> correct 63..63 result with full 16-cycle latency.
